// File: rtl/lcd_text_driver.sv
// HD44780 8-bit text driver: power-up wait, init sequence, then endless two-row refresh frames.
// Latency: one transfer = 1 setup + E_HIGH_CYC enable-high + WAIT_CYC (CLR_WAIT_CYC after 0x01) cycles.
// Backpressure: none; the panel is write-only and purely timed, and line1/line2 are sampled once per frame.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   line1, line2        128-bit ASCII rows, column 0 in bits [127:120]
//   lcd_e/rs/rw/data    HD44780 bus (rw tied low)
//   init_done           high from the end of init until reset
//   frame_done          one-cycle pulse after the last character of row 2 has finished its wait
module lcd_text_driver #(
   parameter int PWR_WAIT_CYC = 50000,
   parameter int E_HIGH_CYC   = 20,
   parameter int WAIT_CYC     = 2000,
   parameter int CLR_WAIT_CYC = 100000
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [127:0] line1,
   input  logic [127:0] line2,
   output logic         lcd_e,
   output logic         lcd_rs,
   output logic         lcd_rw,
   output logic [7:0]   lcd_data,
   output logic         init_done,
   output logic         frame_done
);

   // Counter is wide enough for the largest delay and never narrower than 17 bits.
   localparam int MAX_A = (PWR_WAIT_CYC > CLR_WAIT_CYC) ? PWR_WAIT_CYC : CLR_WAIT_CYC;
   localparam int MAX_B = (WAIT_CYC > E_HIGH_CYC) ? WAIT_CYC : E_HIGH_CYC;
   localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int CNT_W = ($clog2(MAX_C + 1) > 17) ? $clog2(MAX_C + 1) : 17;

   typedef logic [CNT_W-1:0] cnt_t;

   localparam cnt_t PWR_LOAD  = cnt_t'(PWR_WAIT_CYC - 1);
   localparam cnt_t EHI_LOAD  = cnt_t'(E_HIGH_CYC - 1);
   localparam cnt_t WAIT_LOAD = cnt_t'(WAIT_CYC - 1);
   localparam cnt_t CLR_LOAD  = cnt_t'(CLR_WAIT_CYC - 1);

   typedef enum logic [2:0] {
      S_PWR_WAIT, S_INIT, S_SNAP, S_ADDR1, S_ROW1, S_ADDR2, S_ROW2, S_DONE
   } state_t;

   typedef enum logic [1:0] {
      PH_SETUP, PH_EHIGH, PH_WAIT
   } phase_t;

   state_t        state_q, state_d;
   phase_t        phase_q, phase_d;
   cnt_t          cnt_q, cnt_d;
   logic [3:0]    idx_q, idx_d;
   logic [7:0]    byte_q, byte_d;
   logic          rs_q, rs_d;
   logic          init_done_q, init_done_d;
   logic [127:0]  buf1_q, buf1_d;
   logic [127:0]  buf2_q, buf2_d;
   logic          xfer_end;

   function automatic logic [7:0] init_cmd(input logic [1:0] i);
      case (i)
         2'd0:    return 8'h38;   // 8-bit bus, 2 lines, 5x8 font
         2'd1:    return 8'h0C;   // display on, cursor off
         2'd2:    return 8'h06;   // increment, no shift
         default: return 8'h01;   // clear display
      endcase
   endfunction

   // Column 0 lives in the top byte, so shift left by 8*col and take the top byte.
   function automatic logic [7:0] col_byte(input logic [127:0] b, input logic [3:0] c);
      logic [127:0] s;
      s = b << {c, 3'b000};
      return s[127:120];
   endfunction

   always_comb begin
      state_d     = state_q;
      phase_d     = phase_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      byte_d      = byte_q;
      rs_d        = rs_q;
      init_done_d = init_done_q;
      buf1_d      = buf1_q;
      buf2_d      = buf2_q;
      xfer_end    = 1'b0;

      case (state_q)
         S_PWR_WAIT: begin
            if (cnt_q == '0) begin
               state_d = S_INIT;
               phase_d = PH_SETUP;
               idx_d   = 4'd0;
               byte_d  = init_cmd(2'd0);
               rs_d    = 1'b0;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_SNAP: begin
            buf1_d  = line1;
            buf2_d  = line2;
            state_d = S_ADDR1;
            phase_d = PH_SETUP;
            byte_d  = 8'h80;
            rs_d    = 1'b0;
         end
         S_DONE: begin
            state_d = S_SNAP;
         end
         default: begin
            // Transfer primitive shared by INIT, ADDR1, ROW1, ADDR2, ROW2.
            case (phase_q)
               PH_SETUP: begin
                  phase_d = PH_EHIGH;
                  cnt_d   = EHI_LOAD;
               end
               PH_EHIGH: begin
                  if (cnt_q == '0) begin
                     phase_d = PH_WAIT;
                     // Only the clear command needs the long wait; data byte 0x01 does not.
                     cnt_d   = (!rs_q && byte_q == 8'h01) ? CLR_LOAD : WAIT_LOAD;
                  end else begin
                     cnt_d = cnt_q - 1'b1;
                  end
               end
               default: begin
                  if (cnt_q == '0) begin
                     xfer_end = 1'b1;
                  end else begin
                     cnt_d = cnt_q - 1'b1;
                  end
               end
            endcase
         end
      endcase

      // Pick the next transfer (or leave the transfer states) when the wait expires.
      if (xfer_end) begin
         phase_d = PH_SETUP;
         case (state_q)
            S_INIT: begin
               if (idx_q == 4'd3) begin
                  init_done_d = 1'b1;
                  state_d     = S_SNAP;
               end else begin
                  idx_d  = idx_q + 4'd1;
                  byte_d = init_cmd(idx_q[1:0] + 2'd1);
               end
            end
            S_ADDR1: begin
               state_d = S_ROW1;
               idx_d   = 4'd0;
               byte_d  = col_byte(buf1_q, 4'd0);
               rs_d    = 1'b1;
            end
            S_ROW1: begin
               idx_d = idx_q + 4'd1;   // wraps 15 -> 0
               if (idx_q == 4'd15) begin
                  state_d = S_ADDR2;
                  byte_d  = 8'hC0;
                  rs_d    = 1'b0;
               end else begin
                  byte_d = col_byte(buf1_q, idx_q + 4'd1);
               end
            end
            S_ADDR2: begin
               state_d = S_ROW2;
               idx_d   = 4'd0;
               byte_d  = col_byte(buf2_q, 4'd0);
               rs_d    = 1'b1;
            end
            S_ROW2: begin
               idx_d = idx_q + 4'd1;
               if (idx_q == 4'd15) begin
                  state_d = S_DONE;
               end else begin
                  byte_d = col_byte(buf2_q, idx_q + 4'd1);
               end
            end
            default: begin
               state_d = state_q;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_PWR_WAIT;
         phase_q     <= PH_SETUP;
         cnt_q       <= PWR_LOAD;
         idx_q       <= 4'd0;
         byte_q      <= 8'h00;
         rs_q        <= 1'b0;
         init_done_q <= 1'b0;
         buf1_q      <= {16{8'h20}};
         buf2_q      <= {16{8'h20}};
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         byte_q      <= byte_d;
         rs_q        <= rs_d;
         init_done_q <= init_done_d;
         buf1_q      <= buf1_d;
         buf2_q      <= buf2_d;
      end
   end

   // rs/data come straight from registers loaded at transfer start, so they
   // cannot move during the enable pulse or the following wait.
   assign lcd_e      = (phase_q == PH_EHIGH);
   assign lcd_rs     = rs_q;
   assign lcd_rw     = 1'b0;
   assign lcd_data   = byte_q;
   assign init_done  = init_done_q;
   assign frame_done = (state_q == S_DONE);

endmodule

// File: tb/tb_lcd_text_driver.sv
// Bench for lcd_text_driver: expected bus transfers are queued by the stimulus
// process and popped by an independent monitor on each rising edge of lcd_e;
// the stimulus process also checks cycle-exact timing of init and frame events.
module tb_lcd_text_driver;

   localparam int PW  = 10;
   localparam int EH  = 2;
   localparam int WT  = 4;
   localparam int CW  = 8;

   logic         clk;
   logic         rst;
   logic [127:0] line1;
   logic [127:0] line2;
   logic         lcd_e;
   logic         lcd_rs;
   logic         lcd_rw;
   logic [7:0]   lcd_data;
   logic         init_done;
   logic         frame_done;

   lcd_text_driver #(
      .PWR_WAIT_CYC(PW),
      .E_HIGH_CYC  (EH),
      .WAIT_CYC    (WT),
      .CLR_WAIT_CYC(CW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .line1     (line1),
      .line2     (line2),
      .lcd_e     (lcd_e),
      .lcd_rs    (lcd_rs),
      .lcd_rw    (lcd_rw),
      .lcd_data  (lcd_data),
      .init_done (init_done),
      .frame_done(frame_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   logic [8:0] exp_q[$];
   int tests = 0;
   int fails = 0;
   int n;
   int rst_events = 0;
   int rw_ones = 0;

   localparam logic [127:0] TXT1 = "PRESS * TO START";
   localparam logic [127:0] TXT2 = "MONEY: 01000    ";
   localparam logic [127:0] TXTA = {16{8'h41}};

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
      tests++;
      if (got !== req) begin
         fails++;
         $display("FAIL %s: got %0h, required %0h", name, got, req);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      n++;
   endtask

   task automatic push_init();
      exp_q.push_back({1'b0, 8'h38});
      exp_q.push_back({1'b0, 8'h0C});
      exp_q.push_back({1'b0, 8'h06});
      exp_q.push_back({1'b0, 8'h01});
   endtask

   task automatic push_row(input logic [127:0] l, input int cols);
      for (int i = 0; i < cols; i++) exp_q.push_back({1'b1, l[127-8*i -: 8]});
   endtask

   task automatic push_frame(input logic [127:0] l1, input logic [127:0] l2);
      exp_q.push_back({1'b0, 8'h80});
      push_row(l1, 16);
      exp_q.push_back({1'b0, 8'hC0});
      push_row(l2, 16);
   endtask

   // From reset release (n=-1): power wait, init, then first frame.
   task automatic startup_checks(input string tag);
      logic e_early;
      e_early = 1'b0;
      do begin
         tick();
         if (lcd_e === 1'b1) e_early = 1'b1;
      end while (lcd_data !== 8'h38 && n < 100);
      check({tag, "_first_setup_cycle"}, n, PW);
      check({tag, "_e_low_in_pwr_wait"}, e_early, 1'b0);
      check({tag, "_first_setup_rs"}, lcd_rs, 1'b0);
      check({tag, "_first_setup_e"}, lcd_e, 1'b0);
      do tick(); while (init_done !== 1'b1 && n < 200);
      // 3 normal init transfers of 7 cycles, then 0x01 with 1+2+8 cycles
      check({tag, "_init_done_cycle"}, n, PW + 3 * 7 + 11);
      do tick(); while (frame_done !== 1'b1 && n < 600);
      check({tag, "_frame_done_cycle"}, n, 42 + 1 + 34 * 7);
   endtask

   // Scoreboard monitor.
   initial begin : monitor
      logic       prev_e;
      logic [8:0] cap;
      logic [8:0] req;
      int         e_len;
      int         rst_mark;
      prev_e   = 1'b0;
      cap      = '0;
      e_len    = 0;
      rst_mark = 0;
      forever begin
         @(negedge clk);
         if (lcd_rw !== 1'b0) rw_ones++;
         if (lcd_e === 1'b1 && !prev_e) begin
            cap      = {lcd_rs, lcd_data};
            e_len    = 1;
            rst_mark = rst_events;
            tests++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL sb_unexpected: got rs=%0b data=%02h, required no transfer", lcd_rs, lcd_data);
            end else begin
               req = exp_q.pop_front();
               if (cap !== req) begin
                  fails++;
                  $display("FAIL sb_transfer: got rs=%0b data=%02h, required rs=%0b data=%02h",
                           cap[8], cap[7:0], req[8], req[7:0]);
               end
            end
         end else if (lcd_e === 1'b1 && prev_e) begin
            e_len++;
            tests++;
            if ({lcd_rs, lcd_data} !== cap) begin
               fails++;
               $display("FAIL stable_during_e: got rs=%0b data=%02h, required rs=%0b data=%02h",
                        lcd_rs, lcd_data, cap[8], cap[7:0]);
            end
         end else if (lcd_e !== 1'b1 && prev_e) begin
            if (rst_mark == rst_events) begin
               tests++;
               if (e_len != EH) begin
                  fails++;
                  $display("FAIL e_width: got %0d cycles, required %0d", e_len, EH);
               end
            end
         end
         prev_e = (lcd_e === 1'b1);
      end
   end

   initial begin : stimulus
      rst   = 1'b1;
      line1 = TXT1;
      line2 = TXT2;
      n     = -1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_lcd_e", lcd_e, 1'b0);
      check("rst_lcd_rs", lcd_rs, 1'b0);
      check("rst_lcd_rw", lcd_rw, 1'b0);
      check("rst_lcd_data", lcd_data, 8'h00);
      check("rst_init_done", init_done, 1'b0);
      check("rst_frame_done", frame_done, 1'b0);

      push_init();
      push_frame(TXT1, TXT2);
      @(posedge clk);
      #1 rst = 1'b0;
      n = -1;

      startup_checks("boot");
      // Frame 2 keeps the old text even though line1 changes mid-ROW1; frame 3 shows it.
      push_frame(TXT1, TXT2);
      push_frame(TXTA, TXT2);
      tick();
      check("frame_done_one_cycle", frame_done, 1'b0);

      while (n < 300) tick();
      line1 = TXTA;

      do tick(); while (frame_done !== 1'b1 && n < 800);
      check("frame2_done_cycle", n, 281 + 240);
      // Frame 4 is cut short by reset during row-2 column 2's enable pulse.
      exp_q.push_back({1'b0, 8'h80});
      push_row(TXTA, 16);
      exp_q.push_back({1'b0, 8'hC0});
      push_row(TXT2, 3);

      do tick(); while (frame_done !== 1'b1 && n < 1000);
      check("frame3_done_cycle", n, 281 + 480);

      while (n < 904) tick();
      check("row2_e_high_before_rst", lcd_e, 1'b1);
      check("row2_data_before_rst", lcd_data, 8'h4E);

      rst_events++;
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      n = -1;
      tick();
      check("midrst_lcd_e", lcd_e, 1'b0);
      check("midrst_init_done", init_done, 1'b0);
      check("midrst_lcd_data", lcd_data, 8'h00);
      check("midrst_lcd_rs", lcd_rs, 1'b0);
      check("midrst_queue_drained", exp_q.size(), 0);

      push_init();
      push_frame(TXTA, TXT2);
      startup_checks("rerun");
      tick();

      check("final_queue_drained", exp_q.size(), 0);
      check("rw_never_high", rw_ones, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
